// File: rtl/tm_loader.sv
// Turing machine loader: fills instruction memory and tape RAM from a word stream,
// then releases the machine (tm_run) once the last write has been presented.
`timescale 1ns/1ps
module tm_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_SIZE      = 14,
  parameter int INPT_MEM_SIZE = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     inst_we,
  output logic [MEM_SIZE:0]        inst_waddr,
  output logic [DATA_WIDTH-1:0]    inst_wdata,
  output logic                     tape_we,
  output logic [INPT_MEM_SIZE-1:0] tape_waddr,
  output logic                     tape_wdata,
  output logic                     tm_run,
  output logic                     busy,
  output logic                     err
);

  localparam int HW = DATA_WIDTH / 2;
  localparam int IW = MEM_SIZE + 2;
  localparam int TW = INPT_MEM_SIZE + 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [31:0] INST_LIMIT = 32'd1 << (MEM_SIZE + 1);
  localparam logic [31:0] TAPE_LIMIT = 32'd1 << INPT_MEM_SIZE;

  // FLUSH holds the machine for the cycle in which the final instruction write is presented.
  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_INST, S_FLUSH, S_TAPE_FETCH, S_TAPE_SHIFT, S_DONE, S_ERR
  } state_e;

  state_e                  state_q, state_d;
  logic [HW-1:0]           inst_cnt_q, inst_cnt_d;
  logic [HW-1:0]           tape_len_q, tape_len_d;
  logic [IW-1:0]           inst_idx_q, inst_idx_d;
  logic [TW-1:0]           tape_idx_q, tape_idx_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    inst_we_q, inst_we_d;
  logic [MEM_SIZE:0]       inst_waddr_q, inst_waddr_d;
  logic [DATA_WIDTH-1:0]   inst_wdata_q, inst_wdata_d;

  logic                    xfer;
  logic [HW-1:0]           hdr_inst;
  logic [HW-1:0]           hdr_tape;

  assign in_ready = (state_q == S_HEADER) || (state_q == S_INST) || (state_q == S_TAPE_FETCH);
  assign xfer     = in_valid && in_ready;
  assign hdr_inst = in_data[DATA_WIDTH-1:HW];
  assign hdr_tape = in_data[HW-1:0];

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    inst_cnt_d   = inst_cnt_q;
    tape_len_d   = tape_len_q;
    inst_idx_d   = inst_idx_q;
    tape_idx_d   = tape_idx_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    inst_we_d    = 1'b0;
    inst_waddr_d = inst_waddr_q;
    inst_wdata_d = inst_wdata_q;
    tape_we      = 1'b0;
    tm_run       = 1'b0;
    busy         = 1'b1;
    err          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (load_start) begin
          state_d    = S_HEADER;
          inst_idx_d = '0;
          tape_idx_d = '0;
        end
      end
      S_HEADER: begin
        if (xfer) begin
          inst_cnt_d = hdr_inst;
          tape_len_d = hdr_tape;
          if ((32'(hdr_inst) > INST_LIMIT) || (32'(hdr_tape) > TAPE_LIMIT)) begin
            state_d = S_ERR;
          end else if (hdr_inst != '0) begin
            state_d = S_INST;
          end else if (hdr_tape != '0) begin
            state_d = S_TAPE_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_INST: begin
        if (xfer) begin
          inst_we_d    = 1'b1;
          inst_waddr_d = inst_idx_q[MEM_SIZE:0];
          inst_wdata_d = in_data;
          inst_idx_d   = inst_idx_q + IW'(1);
          if (32'(inst_idx_q) + 32'd1 == 32'(inst_cnt_q)) begin
            state_d = (tape_len_q != '0) ? S_TAPE_FETCH : S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_DONE;
      end
      S_TAPE_FETCH: begin
        if (xfer) begin
          shift_d   = in_data;
          bit_cnt_d = '0;
          state_d   = S_TAPE_SHIFT;
        end
      end
      S_TAPE_SHIFT: begin
        tape_we    = 1'b1;
        shift_d    = shift_q >> 1;
        bit_cnt_d  = bit_cnt_q + BW'(1);
        tape_idx_d = tape_idx_q + TW'(1);
        // Reaching tape_len wins over the word boundary, dropping any unused tail bits.
        if (32'(tape_idx_q) + 32'd1 == 32'(tape_len_q)) begin
          state_d = S_DONE;
        end else if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
          state_d = S_TAPE_FETCH;
        end
      end
      S_DONE: begin
        busy   = 1'b0;
        tm_run = !load_start;
        if (load_start) begin
          state_d    = S_HEADER;
          inst_idx_d = '0;
          tape_idx_d = '0;
        end
      end
      S_ERR: begin
        busy = 1'b0;
        err  = 1'b1;
        if (load_start) begin
          state_d    = S_HEADER;
          inst_idx_d = '0;
          tape_idx_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tape_waddr = tape_we ? tape_idx_q[INPT_MEM_SIZE-1:0] : '0;
  assign tape_wdata = tape_we & shift_q[0];
  assign inst_we    = inst_we_q;
  assign inst_waddr = inst_waddr_q;
  assign inst_wdata = inst_wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state_q      <= S_IDLE;
      inst_cnt_q   <= '0;
      tape_len_q   <= '0;
      inst_idx_q   <= '0;
      tape_idx_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      inst_we_q    <= 1'b0;
      inst_waddr_q <= '0;
      inst_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      inst_cnt_q   <= inst_cnt_d;
      tape_len_q   <= tape_len_d;
      inst_idx_q   <= inst_idx_d;
      tape_idx_q   <= tape_idx_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      inst_we_q    <= inst_we_d;
      inst_waddr_q <= inst_waddr_d;
      inst_wdata_q <= inst_wdata_d;
    end
  end

endmodule

// File: tb/tb_tm_loader.sv
// Scoreboard bench for tm_loader: expected writes are queued as words are sent and
// popped by a negedge monitor as the loader presents them.
`timescale 1ns/1ps
module tb_tm_loader;

  localparam int DW  = 32;
  localparam int MS  = 14;
  localparam int IMS = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          inst_we;
  logic [MS:0]   inst_waddr;
  logic [DW-1:0] inst_wdata;
  logic          tape_we;
  logic [IMS-1:0] tape_waddr;
  logic          tape_wdata;
  logic          tm_run;
  logic          busy;
  logic          err;

  tm_loader #(.DATA_WIDTH(DW), .MEM_SIZE(MS), .INPT_MEM_SIZE(IMS)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .inst_we    (inst_we),
    .inst_waddr (inst_waddr),
    .inst_wdata (inst_wdata),
    .tape_we    (tape_we),
    .tape_waddr (tape_waddr),
    .tape_wdata (tape_wdata),
    .tm_run     (tm_run),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t  exp_inst[$];
  wr_t  exp_tape[$];
  wr_t  mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_inst_wr = 0;
  int   n_tape_wr = 0;
  int   last_wr_cyc = -1;
  int   run_rise_cyc = -1;
  logic prev_run = 1'b0;

  always @(posedge clk) cyc++;

  // Monitor: every presented write must match the head of its expected queue.
  always @(negedge clk) begin
    if (rst) begin
      if (inst_we || tape_we) begin
        n_checks++;
        if (inst_we && tape_we) begin
          n_fail++;
          $display("FAIL we_exclusive: inst_we=1 and tape_we=1 in cycle %0d, required at most one", cyc);
        end
      end
      if (inst_we) begin
        n_inst_wr++;
        last_wr_cyc = cyc;
        n_checks++;
        if (exp_inst.size() == 0) begin
          n_fail++;
          $display("FAIL inst_write: unexpected addr=%0d data=%h, required no write", inst_waddr, inst_wdata);
        end else begin
          mon_e = exp_inst.pop_front();
          if (int'(inst_waddr) !== mon_e.addr || inst_wdata !== mon_e.data) begin
            n_fail++;
            $display("FAIL inst_write: got addr=%0d data=%h, required addr=%0d data=%h",
                     inst_waddr, inst_wdata, mon_e.addr, mon_e.data);
          end
        end
      end
      if (tape_we) begin
        n_tape_wr++;
        last_wr_cyc = cyc;
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL ready_while_shift: in_ready=%b, required 0", in_ready);
        end
        n_checks++;
        if (exp_tape.size() == 0) begin
          n_fail++;
          $display("FAIL tape_write: unexpected addr=%0d bit=%b, required no write", tape_waddr, tape_wdata);
        end else begin
          mon_e = exp_tape.pop_front();
          if (int'(tape_waddr) !== mon_e.addr || tape_wdata !== mon_e.data[0]) begin
            n_fail++;
            $display("FAIL tape_write: got addr=%0d bit=%b, required addr=%0d bit=%b",
                     tape_waddr, tape_wdata, mon_e.addr, mon_e.data[0]);
          end
        end
      end
      if (tm_run && !prev_run) run_rise_cyc = cyc;
    end
    prev_run = tm_run;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick(1);
    load_start = 1'b0;
  endtask

  // Returns the cycle whose closing edge transferred the word, or -1 on timeout.
  task automatic send_word(input logic [DW-1:0] w, output int xcyc);
    in_valid = 1'b1;
    in_data  = w;
    xcyc     = -1;
    for (int i = 0; i < 100 && xcyc < 0; i++) begin
      @(negedge clk);
      if (in_ready) xcyc = cyc;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = $urandom;
    if (xcyc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: word %h not accepted within 100 cycles", w);
    end
  endtask

  task automatic push_inst(input int addr, input logic [DW-1:0] w);
    wr_t e;
    e.addr = addr;
    e.data = w;
    exp_inst.push_back(e);
  endtask

  task automatic push_tape(input int base, input logic [DW-1:0] w, input int nbits);
    wr_t e;
    for (int i = 0; i < nbits; i++) begin
      e.addr = base + i;
      e.data = {{(DW-1){1'b0}}, w[i]};
      exp_tape.push_back(e);
    end
  endtask

  task automatic wait_run(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (tm_run) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_timeout: tm_run=%b after 2000 cycles, required 1", tm_run);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    @(negedge clk);
    rst = 1'b1;
    tick(1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    tick(2);
    n_checks++;
    if ({in_ready, inst_we, inst_waddr, inst_wdata, tape_we, tape_waddr, tape_wdata, tm_run, busy, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b iwe=%b ia=%0d id=%h twe=%b ta=%0d td=%b run=%b busy=%b err=%b, required all 0",
               in_ready, inst_we, inst_waddr, inst_wdata, tape_we, tape_waddr, tape_wdata, tm_run, busy, err);
    end
    @(negedge clk);
    rst = 1'b1;
    tick(1);
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || tm_run !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_state: busy=%b in_ready=%b tm_run=%b, required 0 0 0", busy, in_ready, tm_run);
    end
  endtask

  task automatic test_reset_mid_load();
    int xc;
    pulse_start();
    send_word({16'd0, 16'd40}, xc);
    push_tape(0, 32'h0000_0005, 32);
    send_word(32'h0000_0005, xc);
    tick(3);
    n_checks++;
    if (tape_we !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_shift: tape_we=%b before reset, required 1", tape_we);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, inst_we, inst_waddr, inst_wdata, tape_we, tape_waddr, tape_wdata, tm_run, busy, err} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%b twe=%b ta=%0d td=%b run=%b busy=%b, required all 0",
               in_ready, tape_we, tape_waddr, tape_wdata, tm_run, busy);
    end
    exp_tape.delete();
    @(negedge clk);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic test_inst_only();
    int xc;
    int i0, t0;
    bit ok;
    logic [DW-1:0] words [3];
    words[0] = 32'hA0A0_0001;
    words[1] = 32'hB0B0_0002;
    words[2] = 32'hC0C0_0003;
    i0 = n_inst_wr;
    t0 = n_tape_wr;
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || tm_run !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL header_state: busy=%b tm_run=%b in_ready=%b, required 1 0 1", busy, tm_run, in_ready);
    end
    send_word({16'd3, 16'd0}, xc);
    for (int i = 0; i < 3; i++) begin
      push_inst(i, words[i]);
      send_word(words[i], xc);
    end
    wait_run(ok);
    n_checks++;
    if (last_wr_cyc !== xc + 1) begin
      n_fail++;
      $display("FAIL inst_latency: last write cycle %0d, required %0d", last_wr_cyc, xc + 1);
    end
    n_checks++;
    if (run_rise_cyc !== last_wr_cyc + 1) begin
      n_fail++;
      $display("FAIL inst_run_timing: tm_run rose cycle %0d, required %0d", run_rise_cyc, last_wr_cyc + 1);
    end
    n_checks++;
    if (n_inst_wr - i0 !== 3 || n_tape_wr - t0 !== 0 || exp_inst.size() !== 0) begin
      n_fail++;
      $display("FAIL inst_counts: inst=%0d tape=%0d pending=%0d, required 3 0 0",
               n_inst_wr - i0, n_tape_wr - t0, exp_inst.size());
    end
  endtask

  task automatic test_tape();
    int xc;
    int i0, t0;
    bit ok;
    i0 = n_inst_wr;
    t0 = n_tape_wr;
    pulse_start();
    send_word({16'd0, 16'd40}, xc);
    push_tape(0, 32'h0000_0005, 32);
    push_tape(32, 32'h0000_00FF, 8);
    send_word(32'h0000_0005, xc);
    send_word(32'h0000_00FF, xc);
    wait_run(ok);
    n_checks++;
    if (n_tape_wr - t0 !== 40 || n_inst_wr - i0 !== 0 || exp_tape.size() !== 0) begin
      n_fail++;
      $display("FAIL tape_counts: tape=%0d inst=%0d pending=%0d, required 40 0 0",
               n_tape_wr - t0, n_inst_wr - i0, exp_tape.size());
    end
    n_checks++;
    if (last_wr_cyc !== xc + 8) begin
      n_fail++;
      $display("FAIL tape_latency: last bit cycle %0d, required %0d", last_wr_cyc, xc + 8);
    end
    n_checks++;
    if (run_rise_cyc !== last_wr_cyc + 1) begin
      n_fail++;
      $display("FAIL tape_run_timing: tm_run rose cycle %0d, required %0d", run_rise_cyc, last_wr_cyc + 1);
    end
  endtask

  task automatic test_header_limits();
    int xc;
    int i0, t0;
    bit ok;
    i0 = n_inst_wr;
    t0 = n_tape_wr;
    pulse_start();
    send_word({16'h8001, 16'd0}, xc);
    tick(2);
    n_checks++;
    if (err !== 1'b1 || tm_run !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL oversize_inst: err=%b run=%b busy=%b rdy=%b, required 1 0 0 0", err, tm_run, busy, in_ready);
    end
    pulse_start();
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL err_clear: err=%b busy=%b, required 0 1", err, busy);
    end
    // Empty load straight after the error clears.
    send_word({16'd0, 16'd0}, xc);
    wait_run(ok);
    n_checks++;
    if (run_rise_cyc !== xc + 1) begin
      n_fail++;
      $display("FAIL empty_run_timing: tm_run rose cycle %0d, required %0d", run_rise_cyc, xc + 1);
    end
    n_checks++;
    if (n_inst_wr - i0 !== 0 || n_tape_wr - t0 !== 0) begin
      n_fail++;
      $display("FAIL no_writes: inst=%0d tape=%0d, required 0 0", n_inst_wr - i0, n_tape_wr - t0);
    end
    pulse_start();
    send_word({16'd0, 16'h4001}, xc);
    tick(1);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL oversize_tape: err=%b, required 1", err);
    end
    pulse_start();
    send_word({16'h8000, 16'h4000}, xc);
    tick(1);
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL max_counts: err=%b busy=%b rdy=%b, required 0 1 1", err, busy, in_ready);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    int xc;
    int i0, t0;
    bit ok;
    i0 = n_inst_wr;
    t0 = n_tape_wr;
    pulse_start();
    send_word({16'd2, 16'd12}, xc);
    tick(2);
    push_inst(0, 32'h1234_5678);
    send_word(32'h1234_5678, xc);
    tick(1);
    pulse_start();
    tick(1);
    push_inst(1, 32'h9ABC_DEF0);
    send_word(32'h9ABC_DEF0, xc);
    tick(3);
    push_tape(0, 32'hDEAD_BA5C, 12);
    send_word(32'hDEAD_BA5C, xc);
    wait_run(ok);
    n_checks++;
    if (n_inst_wr - i0 !== 2 || n_tape_wr - t0 !== 12 || exp_inst.size() !== 0 || exp_tape.size() !== 0) begin
      n_fail++;
      $display("FAIL gapped_counts: inst=%0d tape=%0d pending=%0d/%0d, required 2 12 0/0",
               n_inst_wr - i0, n_tape_wr - t0, exp_inst.size(), exp_tape.size());
    end
    n_checks++;
    if (run_rise_cyc !== last_wr_cyc + 1) begin
      n_fail++;
      $display("FAIL gapped_run_timing: tm_run rose cycle %0d, required %0d", run_rise_cyc, last_wr_cyc + 1);
    end
    n_checks++;
    if (tm_run !== 1'b1) begin
      n_fail++;
      $display("FAIL done_hold: tm_run=%b, required 1", tm_run);
    end
    load_start = 1'b1;
    #1;
    n_checks++;
    if (tm_run !== 1'b0) begin
      n_fail++;
      $display("FAIL run_drop: tm_run=%b during load_start in DONE, required 0", tm_run);
    end
    tick(1);
    load_start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || tm_run !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_state: busy=%b tm_run=%b, required 1 0", busy, tm_run);
    end
    i0 = n_inst_wr;
    t0 = n_tape_wr;
    send_word({16'd1, 16'd3}, xc);
    tick(1);
    push_inst(0, 32'h0BAD_F00D);
    send_word(32'h0BAD_F00D, xc);
    tick(2);
    push_tape(0, 32'h0000_0006, 3);
    send_word(32'h0000_0006, xc);
    wait_run(ok);
    n_checks++;
    if (n_inst_wr - i0 !== 1 || n_tape_wr - t0 !== 3 || exp_inst.size() !== 0 || exp_tape.size() !== 0) begin
      n_fail++;
      $display("FAIL reload_counts: inst=%0d tape=%0d, required 1 3", n_inst_wr - i0, n_tape_wr - t0);
    end
    n_checks++;
    if (run_rise_cyc !== xc + 4) begin
      n_fail++;
      $display("FAIL reload_run_timing: tm_run rose cycle %0d, required %0d", run_rise_cyc, xc + 4);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_inst_only();
    test_tape();
    test_header_limits();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
